// File: rtl/shift_piso.sv
// shift_piso: parallel-in serial-out shift transmitter.
//
// Accepts a WIDTH-bit word through a valid/ready handshake and sends it one
// bit per clk on s_out, framed by s_valid and s_last. Frames may run back to
// back: a word offered during the final bit of a frame is loaded at that
// edge and its first bit follows with no idle cycle.
//
// Parameters:
//   WIDTH      parallel word width in bits (>= 2)
//   MSB_FIRST  1: send p_in[WIDTH-1] first; 0: send p_in[0] first
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   p_in      parallel word, sampled when in_valid && in_ready
//   in_valid  p_in holds a word to send
//   in_ready  block can accept a word this cycle (combinational)
//   s_out     serial data bit (registered)
//   s_valid   s_out carries a frame bit this cycle (registered)
//   s_last    final bit of the frame (registered)
//   busy      frame in progress, identical to s_valid
//
// Build option:
//   PISO_PARITY_EN  when defined, each frame is followed by one even-parity
//                   bit (XOR of the word) which carries s_last; the frame
//                   becomes WIDTH+1 cycles long.

module shift_piso #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] p_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
`ifdef PISO_PARITY_EN
        StShift = 2'd1,
        StPar   = 2'd2
`else
        StShift = 2'd1
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             s_out_q, s_out_d;
    logic             s_valid_q, s_valid_d;
    logic             s_last_q, s_last_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             final_bit;
    logic             accept;
    logic [WIDTH-1:0] shreg_next;
    logic [CntW-1:0]  cnt_next;

    // Bit of a word that goes on the line first.
    function automatic logic lead_bit(input logic [WIDTH-1:0] word);
        return MSB_FIRST ? word[WIDTH-1] : word[0];
    endfunction

    // The bit currently on the line always sits at the lead position of
    // shreg_q, so advancing is a plain shift toward that end.
    always_comb begin
        shreg_next = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        cnt_next   = cnt_q + CntW'(1);
    end

    // Final bit cycle of a frame: the only cycle besides idle that may take
    // a new word, which keeps the stream gap-free.
    always_comb begin
        final_bit = 1'b0;
        case (state_q)
`ifdef PISO_PARITY_EN
            StPar:   final_bit = 1'b1;
`else
            StShift: final_bit = (cnt_q == LastCnt);
`endif
            default: final_bit = 1'b0;
        endcase
    end

    assign in_ready = (state_q == StIdle) || final_bit;
    assign accept   = in_valid && in_ready;

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so that s_out/s_valid/s_last come straight from flops.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        s_out_d   = 1'b0;
        s_valid_d = 1'b0;
        s_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
        par_d     = par_q;
`endif

        if (accept) begin
            state_d   = StShift;
            shreg_d   = p_in;
            cnt_d     = '0;
            s_out_d   = lead_bit(p_in);
            s_valid_d = 1'b1;
            s_last_d  = 1'b0;  // WIDTH >= 2, so bit 0 is never the last
`ifdef PISO_PARITY_EN
            par_d     = ^p_in;
`endif
        end else begin
            case (state_q)
                StShift: begin
                    if (cnt_q != LastCnt) begin
                        state_d   = StShift;
                        shreg_d   = shreg_next;
                        cnt_d     = cnt_next;
                        s_out_d   = lead_bit(shreg_next);
                        s_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
                        s_last_d  = 1'b0;
`else
                        s_last_d  = (cnt_next == LastCnt);
`endif
                    end else begin
`ifdef PISO_PARITY_EN
                        // Data done; the parity bit closes the frame.
                        state_d   = StPar;
                        s_out_d   = par_q;
                        s_valid_d = 1'b1;
                        s_last_d  = 1'b1;
`else
                        state_d   = StIdle;
                        shreg_d   = '0;
                        cnt_d     = '0;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                StPar: begin
                    state_d = StIdle;
                    shreg_d = '0;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
`endif
                default: begin
                    state_d = StIdle;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            s_out_q   <= 1'b0;
            s_valid_q <= 1'b0;
            s_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            s_out_q   <= s_out_d;
            s_valid_q <= s_valid_d;
            s_last_q  <= s_last_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign s_out   = s_out_q;
    assign s_valid = s_valid_q;
    assign s_last  = s_last_q;
    assign busy    = s_valid_q;

endmodule

// File: doc/shift_piso.md
Name: shift_piso

Overview:
Parallel-in serial-out shift transmitter, the sending end of the serial link that Shift_SIPO receives.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clk on s_out.
- Frames are qualified by s_valid and marked by s_last, and may be issued back to back with no idle gap.
- Default bit order is MSB first, so s_out wired directly to Shift_SIPO.s_in reassembles the word in q_out.

Parameters:
WIDTH, 4, parallel word width in bits (>= 2)
MSB_FIRST, 1, 1 = transmit p_in[WIDTH-1] first; 0 = transmit p_in[0] first

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
p_in  input  WIDTH  parallel word, sampled when in_valid && in_ready
in_valid  input  1  p_in holds a word to send
in_ready  output  1  block can accept a word this cycle
s_out  output  1  serial data bit
s_valid  output  1  s_out carries a frame bit this cycle
s_last  output  1  current bit is the final bit of the frame
busy  output  1  frame in progress (equals s_valid)

Behaviour:
- Reset, while rst_n low and asynchronous: state=IDLE, shift register=0, bit counter=0.
  - Outputs during reset: s_out=0, s_valid=0, s_last=0, busy=0, in_ready=1.
- States are IDLE and SHIFT, plus PAR when PISO_PARITY_EN is defined.
- IDLE:
  - s_valid=0, s_out=0.
  - On in_valid=1 at a clk edge: load p_in into the shift register, clear the counter, go to SHIFT.
- Latency: the first serial bit appears on s_out in the cycle immediately after the accepting edge.
- SHIFT:
  - One bit per cycle, s_valid=1.
  - Bit order: MSB_FIRST=1 gives bits WIDTH-1 down to 0; MSB_FIRST=0 gives bits 0 up to WIDTH-1.
  - Counter increments 0..WIDTH-1 and never wraps past WIDTH-1 inside a frame.
  - s_last=1 exactly when counter==WIDTH-1, without parity.
- in_ready (combinational):
  - 1 in IDLE.
  - 1 in the final bit cycle of a frame (the last SHIFT cycle, or the PAR cycle).
  - 0 otherwise.
- Final-cycle transitions:
  - in_valid=1: reload p_in, stay in or return to SHIFT. The next frame's first bit follows with no gap and s_valid stays 1.
  - in_valid=0: go to IDLE.
- in_valid while in_ready=0: ignored. The word is not captured, and the frame in flight is unaffected.
- p_in changes after acceptance: no effect. The word is held in an internal register.
- rst_n asserted mid-frame: frame aborted immediately. Outputs take reset values with no s_last. After release the block resumes in IDLE.
- All outputs except in_ready are registered. No combinational path from in_valid to s_out.
- Receiver compatibility: after s_last of a WIDTH=4 MSB-first frame, Shift_SIPO.q_out equals the sent word one clk later.

Optional Feature:
PISO_PARITY_EN
- Defined:
  - After the WIDTH data bits, a PAR state emits one even-parity bit (XOR of the word) with s_valid=1 and s_last=1.
  - The last data bit has s_last=0.
  - Frame is WIDTH+1 cycles, and in_ready is asserted in the PAR cycle instead of the last data cycle.
- Undefined:
  - No PAR state and no parity logic.
  - Frame is exactly WIDTH cycles.

Test Plan:
- WIDTH=4, MSB_FIRST=1, load 4'b1011 once -> s_out = 1,0,1,1 in cycles 1-4 after acceptance; s_valid=1 for 4 cycles; s_last only in cycle 4; then IDLE with s_out=0.
- Chain s_out into Shift_SIPO, send 4'b0110 -> q_out==4'b0110 one clk after s_last.
- Hold in_valid with 4'b1100 then 4'b0011 -> 8 contiguous bits 1,1,0,0,0,0,1,1; s_valid never drops; s_last in cycles 4 and 8; in_ready high only in cycles 4 and 8.
- Pulse in_valid with 4'b1111 in cycle 2 of a 4'b0000 frame -> ignored; serial stream is 0,0,0,0; no second frame.
- rst_n low for 1 cycle during bit 2 of 4'b1010 -> s_out, s_valid, s_last, busy drop to 0 asynchronously; in_ready=1; a new 4'b0101 after release is sent cleanly.
- MSB_FIRST=0 with 4'b1011 -> 1,1,0,1; with PISO_PARITY_EN -> 1,1,0,1 then parity 1, s_last only on the 5th bit.
